spi_slave: RTL and testbench



---
 rtl/spi_sync_edge.sv | 28 ++
 rtl/spi_slave.sv | 107 ++++++++++
 tb/tb_spi_slave.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sync_edge.sv
// Shift-register synchronizer for one asynchronous input; reports the
// synchronized level plus single-cycle rise/fall strobes.
`timescale 1ns/1ps
module spi_sync_edge #(
    parameter int   STAGES = 3,
    parameter logic IDLE   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sh;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sh <= {STAGES{IDLE}};
        else       r_sh <= {r_sh[STAGES-2:0], i_d};
    end

    // The two oldest taps drive both the level and the edge strobes so they stay coherent
    assign o_level = r_sh[STAGES-2];
    assign o_rise  = (r_sh[STAGES-1:STAGES-2] == 2'b01);
    assign o_fall  = (r_sh[STAGES-1:STAGES-2] == 2'b10);

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave running entirely in the CLK domain. Received frames are
// latched to MSG; MISO replays the running count of received bytes.
`timescale 1ns/1ps
module spi_slave #(
    parameter int SYNC_STAGES = 3,
    parameter int WIDTH       = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SCK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic             SSEL,
    output logic [WIDTH-1:0] MSG,
    output logic             MSG_VALID
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             w_sck_level, w_sck_rise, w_sck_fall;
    logic             w_ssel_level, w_ssel_rise, w_ssel_fall;
    logic             w_active, w_ssel_start, w_mosi;
    logic             w_unused;
    logic [7:0]       w_byte_next;

    logic [SYNC_STAGES-2:0] r_mosi;
    logic [CW-1:0]          r_bit_cnt;
    logic [WIDTH-1:0]       r_rx;
    logic [WIDTH-1:0]       r_msg;
    logic                   r_msg_valid;
    logic                   r_done;
    logic [7:0]             r_byte_cnt;
    logic [7:0]             r_tx;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sck_sync (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_d     (SCK),
        .o_level (w_sck_level),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_ssel_sync (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_d     (SSEL),
        .o_level (w_ssel_level),
        .o_rise  (w_ssel_rise),
        .o_fall  (w_ssel_fall)
    );

    // One stage shorter than SCK: MOSI is sampled the same cycle SCK is first seen high
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_mosi <= '0;
        else     r_mosi <= {r_mosi[SYNC_STAGES-3:0], MOSI};
    end

    assign w_mosi       = r_mosi[SYNC_STAGES-2];
    assign w_active     = ~w_ssel_level;
    assign w_ssel_start = w_ssel_fall;
    assign w_byte_next  = r_byte_cnt + 8'd1;
    assign w_unused     = w_sck_level | w_ssel_rise;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bit_cnt   <= '0;
            r_rx        <= '0;
            r_done      <= 1'b0;
            r_msg       <= '0;
            r_msg_valid <= 1'b0;
            r_byte_cnt  <= 8'd0;
            r_tx        <= 8'd0;
        end else begin
            r_done      <= 1'b0;
            r_msg_valid <= 1'b0;

            if (!w_active) begin
                r_bit_cnt <= '0;
            end else if (w_sck_rise) begin
                r_rx <= {r_rx[WIDTH-2:0], w_mosi};
                if (r_bit_cnt == CW'(WIDTH - 1)) begin
                    r_bit_cnt <= '0;
                    r_done    <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
            end

            if (r_done) begin
                r_msg       <= r_rx;
                r_msg_valid <= 1'b1;
                r_byte_cnt  <= w_byte_next;
            end

            // Frame completion wins over window start; both reload the reply byte
            if (r_done)                       r_tx <= w_byte_next;
            else if (w_ssel_start)            r_tx <= r_byte_cnt;
            else if (w_active && w_sck_fall)  r_tx <= {r_tx[6:0], 1'b0};
        end
    end

    assign MISO      = w_active & r_tx[7];
    assign MSG       = r_msg;
    assign MSG_VALID = r_msg_valid;

endmodule

// File: tb/tb_spi_slave.sv
// Directed and randomized bench for spi_slave with a stream-level reference model.
`timescale 1ns/1ps
module tb_spi_slave;

    logic       CLK  = 1'b0;
    logic       RST  = 1'b1;
    logic       SCK  = 1'b0;
    logic       MOSI = 1'b0;
    logic       SSEL = 1'b1;
    logic       MISO;
    logic       MSG_VALID;
    logic [7:0] MSG;

    int checks = 0;
    int errors = 0;

    // Observations of the DUT
    int         pulses   = 0;
    int         changes  = 0;
    logic [7:0] prev_msg = 8'h00;
    logic [7:0] msg_q[$];

    // Reference model state
    logic [63:0] win_stream = '0;
    int          win_bits   = 0;
    logic [7:0]  win_cnt    = 8'h00;
    logic [7:0]  exp_msg    = 8'h00;
    logic [7:0]  exp_cnt    = 8'h00;
    int          exp_pulses = 0;

    logic [31:0] mw, d;
    int          p0, c0, e0, n, k;

    spi_slave #(.SYNC_STAGES(3), .WIDTH(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SCK       (SCK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .SSEL      (SSEL),
        .MSG       (MSG),
        .MSG_VALID (MSG_VALID)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (MSG_VALID === 1'b1) begin
            pulses++;
            msg_q.push_back(MSG);
        end
        if (MSG !== prev_msg) changes++;
        prev_msg = MSG;
    end

    task automatic wait_clk(input int cycles);
        repeat (cycles) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Stream model: a window is a bit string; every 8 bits form one frame
    task automatic model_bits(input logic [31:0] data, input int nb);
        int old_frames, new_frames;
        old_frames = win_bits / 8;
        win_stream = (win_stream << nb) | 64'(data & ((32'h1 << nb) - 1));
        win_bits   = win_bits + nb;
        new_frames = win_bits / 8 - old_frames;
        if (new_frames > 0) begin
            exp_msg    = 8'((win_stream >> (win_bits % 8)) & 64'hFF);
            exp_cnt    = 8'(int'(exp_cnt) + new_frames);
            exp_pulses = exp_pulses + new_frames;
        end
    endtask

    // Master side: MOSI and SCK rise together, MISO is sampled just before the rise
    task automatic xfer(input logic [31:0] data, input int nb, input int half, output logic [31:0] miso_w);
        miso_w = '0;
        for (int i = nb - 1; i >= 0; i--) begin
            @(negedge CLK);
            miso_w = {miso_w[30:0], MISO};
            MOSI   = data[i];
            SCK    = 1'b1;
            wait_clk(half);
            SCK    = 1'b0;
            wait_clk(half - 1);
        end
        wait_clk(6);
    endtask

    task automatic sel_on();
        @(negedge CLK);
        SSEL = 1'b0;
        wait_clk(8);
        win_stream = '0;
        win_bits   = 0;
        win_cnt    = exp_cnt;
    endtask

    task automatic sel_off();
        @(negedge CLK);
        SSEL = 1'b1;
        MOSI = 1'b0;
        wait_clk(8);
        win_stream = '0;
        win_bits   = 0;
    endtask

    initial begin
        // Reset state
        wait_clk(5);
        chk("reset_msg",   32'(MSG),       32'h00);
        chk("reset_miso",  32'(MISO),      32'h0);
        chk("reset_valid", 32'(MSG_VALID), 32'h0);
        RST = 1'b0;
        wait_clk(5);

        // Back-to-back 16 bits in one window
        sel_on();
        msg_q.delete();
        p0 = pulses;
        xfer(32'hE355, 16, 10, mw);
        model_bits(32'hE355, 16);
        chk("b2b_pulses", 32'(pulses - p0), 32'd2);
        chk("b2b_first",  32'(msg_q.size() > 0 ? msg_q[0] : 8'hxx), 32'hE3);
        chk("b2b_second", 32'(msg_q.size() > 1 ? msg_q[1] : 8'hxx), 32'h55);
        chk("b2b_msg",    32'(MSG), 32'(exp_msg));
        chk("b2b_miso",   (mw >> 8) & 32'hFF, 32'(win_cnt));
        sel_off();

        // MISO readback of the byte count
        sel_on();
        d = 32'($urandom_range(0, 255));
        xfer(d, 8, 10, mw);
        model_bits(d, 8);
        chk("readback_miso", mw & 32'hFF, 32'(win_cnt));
        chk("readback_msg",  32'(MSG),    32'(exp_msg));
        sel_off();

        // Single frame
        sel_on();
        p0 = pulses;
        xfer(32'hE3, 8, 10, mw);
        model_bits(32'hE3, 8);
        chk("single_msg",    32'(MSG),         32'(exp_msg));
        chk("single_pulses", 32'(pulses - p0), 32'd1);
        chk("single_miso",   mw & 32'hFF,      32'(win_cnt));
        sel_off();

        // Abort after 5 bits, then a full frame
        sel_on();
        p0 = pulses;
        c0 = changes;
        xfer(32'($urandom_range(0, 31)), 5, 10, mw);
        sel_off();
        chk("abort_msg_kept", 32'(MSG), 32'(exp_msg));
        sel_on();
        xfer(32'hA5, 8, 10, mw);
        model_bits(32'hA5, 8);
        chk("abort_pulses",  32'(pulses - p0),  32'd1);
        chk("abort_changes", 32'(changes - c0), 32'd1);
        chk("abort_msg",     32'(MSG),          32'(exp_msg));
        sel_off();

        // SCK activity while deselected
        p0 = pulses;
        c0 = changes;
        xfer(32'hFF, 8, 10, mw);
        MOSI = 1'b0;
        chk("idle_pulses",  32'(pulses - p0),  32'd0);
        chk("idle_changes", 32'(changes - c0), 32'd0);
        chk("idle_miso",    mw & 32'hFF,       32'h00);

        // Randomized windows of arbitrary length
        for (int w = 0; w < 6; w++) begin
            sel_on();
            n  = int'($urandom_range(1, 24));
            d  = $urandom;
            p0 = pulses;
            e0 = exp_pulses;
            xfer(d, n, int'($urandom_range(3, 10)), mw);
            model_bits(d, n);
            chk("rand_msg",    32'(MSG),         32'(exp_msg));
            chk("rand_pulses", 32'(pulses - p0), 32'(exp_pulses - e0));
            if (n >= 8) chk("rand_miso", (mw >> (n - 8)) & 32'hFF, 32'(win_cnt));
            sel_off();
        end

        // Drive the byte counter to 255, then across the wrap
        sel_on();
        k = (255 - int'(exp_cnt)) % 256;
        for (int f = 0; f < k; f++) begin
            d = 32'($urandom_range(0, 255));
            xfer(d, 8, 4, mw);
            model_bits(d, 8);
        end
        sel_off();
        sel_on();
        xfer(32'h96, 8, 10, mw);
        model_bits(32'h96, 8);
        chk("wrap_miso_ff", mw & 32'hFF, 32'(win_cnt));
        chk("wrap_cnt_ff",  32'(win_cnt), 32'hFF);
        sel_off();
        sel_on();
        xfer(32'h3C, 8, 10, mw);
        model_bits(32'h3C, 8);
        chk("wrap_miso_00", mw & 32'hFF, 32'(win_cnt));
        chk("wrap_msg",     32'(MSG),    32'(exp_msg));
        sel_off();

        // Asynchronous reset in the middle of a frame
        sel_on();
        xfer(32'($urandom_range(0, 15)), 4, 10, mw);
        #2 RST = 1'b1;
        #1;
        chk("rst_msg",   32'(MSG),       32'h00);
        chk("rst_miso",  32'(MISO),      32'h0);
        chk("rst_valid", 32'(MSG_VALID), 32'h0);
        exp_msg = 8'h00;
        exp_cnt = 8'h00;
        wait_clk(3);
        RST = 1'b0;
        sel_off();
        sel_on();
        d = 32'($urandom_range(1, 255));
        xfer(d, 8, 10, mw);
        model_bits(d, 8);
        chk("post_rst_miso", mw & 32'hFF, 32'(win_cnt));
        chk("post_rst_msg",  32'(MSG),    32'(exp_msg));
        sel_off();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
